fc_cmd_arbiter: RTL and testbench
=================================

FC_CMD_ARBITER -- requirements
Module: fc_cmd_arbiter

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 128, meaning the internal-memory size used for the command range check.
REQ-002 SHALL have parameter STARVE_MAX, default 4, meaning the maximum consecutive grants to requester 0 in priority mode.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 2, per requester: a command is pending.
REQ-006 SHALL have port req_cmd0, input, 33, requester 0 command: [32] 1=read flash->mem, 0=write; [31:14] flash addr; [13:7] mem addr; [6:0] length.
REQ-007 SHALL have port req_cmd1, input, 33, requester 1 command, same format as req_cmd0.
REQ-008 SHALL have port req_ready, output, 2, one-cycle accept pulse per requester.
REQ-009 SHALL have port rsp_done, output, 2, one-cycle completion pulse to the command owner.
REQ-010 SHALL have port rsp_err, output, 2, one-cycle reject pulse for an illegal command.
REQ-011 SHALL have port fc_cmd, output, 33, the command presented to FC; held stable from issue until fc_done.
REQ-012 SHALL have port fc_go, output, 1, one-cycle pulse telling FC to sample fc_cmd.
REQ-013 SHALL have port fc_done, input, 1, FC pulse: FC is idle and ready for a command.
REQ-014 SHALL have port busy, output, 1, high while a command is owned by FC.
REQ-015 SHALL have port owner, output, 1, the index of the requester whose command is in FC.

Function
REQ-016 SHALL keep a flag fc_idle: set by fc_done, cleared by fc_go; FSM states IDLE, CHECK, ISSUE, BUSY.
REQ-017 IDLE: when any req_valid is high, SHALL select a winner, pulse req_ready[winner], latch its command, and go to CHECK.
REQ-018 Without the priority macro, arbitration SHALL be round-robin: on a tie the winner is the requester not served last; after reset requester 0 is preferred.
REQ-019 CHECK: a command with length==0, or with mem addr + length > MEM_DEPTH (8-bit sum, no wrap), SHALL pulse rsp_err[winner] and return to IDLE without touching FC.
REQ-020 CHECK: a legal command SHALL go to ISSUE.
REQ-021 ISSUE: SHALL wait for fc_idle, then drive fc_cmd, pulse fc_go for one cycle, set busy and owner, and go to BUSY.
REQ-022 BUSY: on fc_done SHALL pulse rsp_done[owner] in the same cycle, clear busy, and go to IDLE; fc_done also sets fc_idle.
REQ-023 A legal command SHALL reach fc_go no earlier than 2 cycles after req_ready when FC is idle.
REQ-024 fc_done arriving outside BUSY SHALL only set fc_idle; no rsp pulse is generated.
REQ-025 Requesters SHALL be served one at a time; a valid arriving while busy waits and has no queue.

Reset
REQ-026 While rst is low SHALL force state IDLE, fc_idle=0, round-robin pointer to 0, the starvation counter to 0, and all outputs to 0 (fc_cmd=0).
REQ-027 Reset asserted mid-command SHALL abandon the command with no rsp pulse after release.

Configuration
REQ-028 SHALL use macro FC_ARB_PRIO_EN; when defined, requester 0 has fixed priority, but after STARVE_MAX consecutive grants to requester 0 a pending requester 1 wins once and the counter clears.
REQ-029 When FC_ARB_PRIO_EN is undefined, SHALL use round-robin only and the STARVE_MAX parameter is unused.

Structure
REQ-030 A shared package fc_pkg SHALL hold the command field offsets, the 33-bit command typedef, and the FSM state enum.
REQ-031 The arbitration decision SHALL live in one sub-module fc_rr_pick (inputs valid and last winner, output winner).

Verification
REQ-032 After reset, fc_done pulse; req_valid=01 with cmd {1,18'h00010,7'd0,7'd16} -> req_ready=01, fc_go 2 cycles later with identical fc_cmd; fc_done -> rsp_done=01.
REQ-033 Both requesters valid continuously for 4 commands -> grants alternate 0,1,0,1 (macro off).
REQ-034 With FC_ARB_PRIO_EN and STARVE_MAX=4, both requesters valid -> grants 0,0,0,0,1,0.
REQ-035 Command with mem addr 7'd120 and length 7'd16 -> rsp_err pulse, no fc_go; length 0 -> rsp_err.
REQ-036 Reset asserted while in BUSY -> all outputs 0 at once; after release no rsp_done until a new request is accepted.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared definitions for the flash-controller command arbiter: command layout,
// FSM state encoding and small combinational helpers.
package fc_pkg;

    localparam int FLASH_W = 18;
    localparam int MEM_W   = 7;
    localparam int LEN_W   = 7;
    localparam int CMD_W   = 1 + FLASH_W + MEM_W + LEN_W;

    // Field order fixes the bit offsets: [32] dir, [31:14] flash, [13:7] mem, [6:0] len.
    typedef struct packed {
        logic               dir;
        logic [FLASH_W-1:0] flash;
        logic [MEM_W-1:0]   mem;
        logic [LEN_W-1:0]   len;
    } fc_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        ISSUE = 2'd2,
        BUSY  = 2'd3
    } fc_state_e;

    function automatic logic fc_cmd_bad(input logic [MEM_W-1:0] mem,
                                        input logic [LEN_W-1:0] len,
                                        input logic [8:0]       limit);
        logic [7:0] sum;
        sum = {1'b0, mem} + {1'b0, len};
        return (len == 7'd0) || ({1'b0, sum} > limit);
    endfunction

    function automatic logic [1:0] fc_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/fc_rr_pick.sv
// Two-way arbitration decision: a lone requester wins, a tie goes to the
// requester that did not win last.
module fc_rr_pick (
    input  logic [1:0] valid_i,
    input  logic       last_i,
    output logic       win_o
);

    // Winner selection from the pending mask and the last winner.
    always_comb begin
        win_o = 1'b0;
        case (valid_i)
            2'b01:   win_o = 1'b0;
            2'b10:   win_o = 1'b1;
            2'b11:   win_o = ~last_i;
            default: win_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/fc_cmd_arbiter.sv
// Arbitrates two command requesters onto one flash controller, range-checks
// each command and tracks ownership. Define FC_ARB_PRIO_EN for fixed priority.
module fc_cmd_arbiter
    import fc_pkg::*;
#(
    parameter int MEM_DEPTH  = 128,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    input  logic [32:0] req_cmd0,
    input  logic [32:0] req_cmd1,
    output logic [1:0]  req_ready,
    output logic [1:0]  rsp_done,
    output logic [1:0]  rsp_err,
    output logic [32:0] fc_cmd,
    output logic        fc_go,
    input  logic        fc_done,
    output logic        busy,
    output logic        owner
);

    localparam logic [8:0] MEM_LIMIT = 9'(MEM_DEPTH);

    if (STARVE_MAX < 1) begin : g_starve_cfg
        $error("fc_cmd_arbiter: STARVE_MAX must be at least 1");
    end

    fc_state_e  state_q;
    logic       fc_idle_q;
    logic       win_q;
    logic       busy_q;
    logic       owner_q;
    logic       fc_go_q;
    logic [1:0] req_ready_q;
    logic [1:0] rsp_done_q;
    logic [1:0] rsp_err_q;
    fc_cmd_t    cmd_q;
    fc_cmd_t    fc_cmd_q;

    logic       win_s;
    logic       last_s;
    logic       cmd_bad_s;
    fc_cmd_t    req_sel_s;

`ifdef FC_ARB_PRIO_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [SW-1:0] starve_q;

    // Requester 0 normally wins ties; once starved, requester 1 is treated as owed.
    always_comb begin
        if (starve_q >= STARVE_LIM) begin
            last_s = 1'b0;
        end else begin
            last_s = 1'b1;
        end
    end

    // Consecutive-grant counter for requester 0, saturating at the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
        end else if (state_q == IDLE && |req_valid) begin
            if (win_s) begin
                starve_q <= '0;
            end else if (starve_q != STARVE_LIM) begin
                starve_q <= starve_q + 1'b1;
            end else begin
                starve_q <= starve_q;
            end
        end else begin
            starve_q <= starve_q;
        end
    end
`else
    logic ptr_q;

    // The pointer names the preferred requester; the picker wants the last winner.
    always_comb begin
        last_s = ~ptr_q;
    end

    // Round-robin pointer: prefer whoever was not granted last.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= 1'b0;
        end else if (state_q == IDLE && |req_valid) begin
            ptr_q <= ~win_s;
        end else begin
            ptr_q <= ptr_q;
        end
    end
`endif

    fc_rr_pick u_pick (
        .valid_i (req_valid),
        .last_i  (last_s),
        .win_o   (win_s)
    );

    // Command mux and legality of the latched command.
    always_comb begin
        req_sel_s = fc_cmd_t'(win_s ? req_cmd1 : req_cmd0);
        cmd_bad_s = fc_cmd_bad(cmd_q.mem, cmd_q.len, MEM_LIMIT);
    end

    // Main FSM with registered pulse and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            fc_idle_q   <= 1'b0;
            win_q       <= 1'b0;
            busy_q      <= 1'b0;
            owner_q     <= 1'b0;
            fc_go_q     <= 1'b0;
            req_ready_q <= 2'b00;
            rsp_done_q  <= 2'b00;
            rsp_err_q   <= 2'b00;
            cmd_q       <= '0;
            fc_cmd_q    <= '0;
        end else begin
            req_ready_q <= 2'b00;
            rsp_done_q  <= 2'b00;
            rsp_err_q   <= 2'b00;
            fc_go_q     <= 1'b0;
            if (fc_done) begin
                fc_idle_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        req_ready_q <= fc_onehot(win_s);
                        win_q       <= win_s;
                        cmd_q       <= req_sel_s;
                        state_q     <= CHECK;
                    end
                end
                CHECK: begin
                    if (cmd_bad_s) begin
                        rsp_err_q <= fc_onehot(win_q);
                        state_q   <= IDLE;
                    end else begin
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Issue clears fc_idle even if a stray fc_done lands on the same edge.
                    if (fc_idle_q) begin
                        fc_cmd_q  <= cmd_q;
                        fc_go_q   <= 1'b1;
                        fc_idle_q <= 1'b0;
                        busy_q    <= 1'b1;
                        owner_q   <= win_q;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    if (fc_done) begin
                        rsp_done_q <= fc_onehot(owner_q);
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_done  = rsp_done_q;
    assign rsp_err   = rsp_err_q;
    assign fc_cmd    = fc_cmd_q;
    assign fc_go     = fc_go_q;
    assign busy      = busy_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_fc_cmd_arbiter.sv
// Self-checking bench for fc_cmd_arbiter: directed scenarios plus a randomized
// run against a transaction-level model of grant order and command legality.
module tb_fc_cmd_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [32:0] req_cmd0;
    logic [32:0] req_cmd1;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_done;
    logic [1:0]  rsp_err;
    logic [32:0] fc_cmd;
    logic        fc_go;
    logic        fc_done;
    logic        busy;
    logic        owner;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: who is preferred on a tie, and the requester-0 grant streak.
    logic m_pref;
    int   m_streak;

    fc_cmd_arbiter dut (
        .clk       (clk),
        .rst       (rst_n),
        .req_valid (req_valid),
        .req_cmd0  (req_cmd0),
        .req_cmd1  (req_cmd1),
        .req_ready (req_ready),
        .rsp_done  (rsp_done),
        .rsp_err   (rsp_err),
        .fc_cmd    (fc_cmd),
        .fc_go     (fc_go),
        .fc_done   (fc_done),
        .busy      (busy),
        .owner     (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_pick(input logic [1:0] v);
        if (v == 2'b01) return 1'b0;
        if (v == 2'b10) return 1'b1;
`ifdef FC_ARB_PRIO_EN
        return (m_streak >= 4);
`else
        return m_pref;
`endif
    endfunction

    task automatic model_grant(input logic w);
        m_pref   = ~w;
        m_streak = w ? 0 : ((m_streak < 4) ? m_streak + 1 : m_streak);
    endtask

    function automatic logic model_legal(input int mem, input int len);
        return (len != 0) && ((mem + len) <= 128);
    endfunction

    function automatic logic [32:0] mk_cmd(input logic dir, input logic [17:0] fa,
                                           input logic [6:0] mem, input logic [6:0] len);
        return {dir, fa, mem, len};
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        fc_done   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        m_pref   = 1'b0;
        m_streak = 0;
        @(negedge clk);
    endtask

    task automatic pulse_done();
        fc_done = 1'b1;
        @(negedge clk);
        fc_done = 1'b0;
    endtask

    task automatic wait_ready(output logic [1:0] got);
        got = 2'b00;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (req_ready !== 2'b00) begin
                got = req_ready;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_cmd0  = mk_cmd(1'b1, 18'h00010, 7'd0, 7'd16);
        req_cmd1  = mk_cmd(1'b0, 18'h00020, 7'd4, 7'd8);
        fc_done   = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({req_ready, rsp_done, rsp_err, fc_go, busy, owner} !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 0", {req_ready, rsp_done, rsp_err, fc_go, busy, owner});
        end
        vectors++;
        if (fc_cmd !== 33'd0) begin
            miscompares++;
            $display("FAIL reset_fc_cmd: got %h want 0", fc_cmd);
        end
        do_reset();
    endtask

    task automatic test_basic();
        logic [1:0]  got;
        logic [32:0] c;
        do_reset();
        pulse_done();
        c = mk_cmd(1'b1, 18'h00010, 7'd0, 7'd16);
        req_cmd0  = c;
        req_valid = 2'b01;
        wait_ready(got);
        req_valid = 2'b00;
        vectors++;
        if (got !== 2'b01) begin miscompares++; $display("FAIL basic_ready: got %b want 01", got); end
        @(negedge clk);
        vectors++;
        if ({fc_go, rsp_err} !== 3'b000) begin miscompares++; $display("FAIL basic_early_go: got %b want 000", {fc_go, rsp_err}); end
        @(negedge clk);
        vectors++;
        if ({fc_go, busy, owner, fc_cmd} !== {1'b1, 1'b1, 1'b0, c}) begin
            miscompares++;
            $display("FAIL basic_issue: got go=%b busy=%b owner=%b cmd=%h want 1 1 0 %h", fc_go, busy, owner, fc_cmd, c);
        end
        @(negedge clk);
        vectors++;
        if ({fc_go, fc_cmd} !== {1'b0, c}) begin miscompares++; $display("FAIL basic_hold: got go=%b cmd=%h want 0 %h", fc_go, fc_cmd, c); end
        pulse_done();
        vectors++;
        if ({rsp_done, busy} !== 3'b010) begin miscompares++; $display("FAIL basic_done: got %b want 010", {rsp_done, busy}); end
        @(negedge clk);
        vectors++;
        if (rsp_done !== 2'b00) begin miscompares++; $display("FAIL basic_done_pulse: got %b want 00", rsp_done); end
    endtask

    task automatic test_fc_wait();
        logic [1:0]  got;
        logic [32:0] c;
        do_reset();
        c = mk_cmd(1'b0, 18'h3ffff, 7'd5, 7'd10);
        req_cmd1  = c;
        req_valid = 2'b10;
        wait_ready(got);
        req_valid = 2'b00;
        vectors++;
        if (got !== 2'b10) begin miscompares++; $display("FAIL wait_ready: got %b want 10", got); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (fc_go !== 1'b0) begin miscompares++; $display("FAIL wait_no_go: got %b want 0", fc_go); end
        end
        fc_done = 1'b1;
        @(negedge clk);
        fc_done = 1'b0;
        vectors++;
        if ({fc_go, rsp_done, busy} !== 4'b0000) begin miscompares++; $display("FAIL wait_stray_done: got %b want 0000", {fc_go, rsp_done, busy}); end
        @(negedge clk);
        vectors++;
        if ({fc_go, owner, fc_cmd} !== {1'b1, 1'b1, c}) begin
            miscompares++;
            $display("FAIL wait_issue: got go=%b owner=%b cmd=%h want 1 1 %h", fc_go, owner, fc_cmd, c);
        end
        pulse_done();
        vectors++;
        if (rsp_done !== 2'b10) begin miscompares++; $display("FAIL wait_done: got %b want 10", rsp_done); end
    endtask

    task automatic test_range();
        logic [1:0] got;
        int mems[5];
        int lens[5];
        logic legal;
        mems[0] = 120; lens[0] = 16;
        mems[1] = 0;   lens[1] = 0;
        mems[2] = 112; lens[2] = 16;
        mems[3] = 127; lens[3] = 127;
        mems[4] = 1;   lens[4] = 127;
        do_reset();
        pulse_done();
        for (int i = 0; i < 5; i++) begin
            legal     = model_legal(mems[i], lens[i]);
            req_cmd0  = mk_cmd(1'b1, 18'(i), 7'(mems[i]), 7'(lens[i]));
            req_valid = 2'b01;
            wait_ready(got);
            req_valid = 2'b00;
            vectors++;
            if (got !== 2'b01) begin miscompares++; $display("FAIL range_ready[%0d]: got %b want 01", i, got); end
            @(negedge clk);
            vectors++;
            if ({rsp_err, fc_go} !== {(legal ? 2'b00 : 2'b01), 1'b0}) begin
                miscompares++;
                $display("FAIL range_err[%0d]: got err=%b go=%b want legal=%b", i, rsp_err, fc_go, legal);
            end
            @(negedge clk);
            vectors++;
            if (fc_go !== legal) begin miscompares++; $display("FAIL range_go[%0d]: got %b want %b", i, fc_go, legal); end
            if (legal) pulse_done();
        end
    endtask

    task automatic test_tie();
        logic [1:0] got;
        logic exp_seq[6];
        int n;
`ifdef FC_ARB_PRIO_EN
        n = 6;
        exp_seq[0] = 1'b0; exp_seq[1] = 1'b0; exp_seq[2] = 1'b0;
        exp_seq[3] = 1'b0; exp_seq[4] = 1'b1; exp_seq[5] = 1'b0;
`else
        n = 4;
        exp_seq[0] = 1'b0; exp_seq[1] = 1'b1; exp_seq[2] = 1'b0;
        exp_seq[3] = 1'b1; exp_seq[4] = 1'b0; exp_seq[5] = 1'b1;
`endif
        do_reset();
        pulse_done();
        req_cmd0  = mk_cmd(1'b1, 18'h00100, 7'd10, 7'd20);
        req_cmd1  = mk_cmd(1'b0, 18'h00200, 7'd30, 7'd40);
        req_valid = 2'b11;
        for (int i = 0; i < n; i++) begin
            wait_ready(got);
            vectors++;
            if (got !== (exp_seq[i] ? 2'b10 : 2'b01)) begin
                miscompares++;
                $display("FAIL tie_grant[%0d]: got %b want requester %0d", i, got, exp_seq[i]);
            end
            repeat (2) @(negedge clk);
            vectors++;
            if ({fc_go, owner} !== {1'b1, exp_seq[i]}) begin
                miscompares++;
                $display("FAIL tie_owner[%0d]: got go=%b owner=%b want 1 %b", i, fc_go, owner, exp_seq[i]);
            end
            if (i == n - 1) req_valid = 2'b00;
            pulse_done();
        end
        req_valid = 2'b00;
    endtask

    task automatic test_reset_mid();
        logic [1:0] got;
        do_reset();
        pulse_done();
        req_cmd0  = mk_cmd(1'b0, 18'h01234, 7'd8, 7'd8);
        req_valid = 2'b01;
        wait_ready(got);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({req_ready, rsp_done, rsp_err, fc_go, busy, owner, fc_cmd} !== 42'd0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got ctrl=%b cmd=%h want 0", {req_ready, rsp_done, rsp_err, fc_go, busy, owner}, fc_cmd);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        m_pref   = 1'b0;
        m_streak = 0;
        fc_done  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            fc_done = 1'b0;
            vectors++;
            if ({rsp_done, busy} !== 3'b000) begin miscompares++; $display("FAIL midrst_no_rsp[%0d]: got %b want 000", i, {rsp_done, busy}); end
        end
        req_cmd1  = mk_cmd(1'b1, 18'h00001, 7'd0, 7'd1);
        req_valid = 2'b10;
        wait_ready(got);
        req_valid = 2'b00;
        vectors++;
        if (got !== 2'b10) begin miscompares++; $display("FAIL midrst_new_req: got %b want 10", got); end
        repeat (2) @(negedge clk);
        pulse_done();
        vectors++;
        if (rsp_done !== 2'b10) begin miscompares++; $display("FAIL midrst_new_done: got %b want 10", rsp_done); end
    endtask

    task automatic test_random();
        logic [1:0]  v;
        logic [1:0]  got;
        logic [32:0] c0;
        logic [32:0] c1;
        logic [32:0] cw;
        logic        w;
        logic        legal;
        int          mem;
        int          len;
        do_reset();
        pulse_done();
        for (int i = 0; i < 40; i++) begin
            v  = 2'($urandom_range(1, 3));
            c0 = mk_cmd(1'($urandom), 18'($urandom), 7'($urandom_range(0, 127)), 7'($urandom_range(0, 40)));
            c1 = mk_cmd(1'($urandom), 18'($urandom), 7'($urandom_range(0, 127)), 7'($urandom_range(0, 40)));
            w  = model_pick(v);
            cw = w ? c1 : c0;
            mem   = int'(cw[13:7]);
            len   = int'(cw[6:0]);
            legal = model_legal(mem, len);
            req_cmd0  = c0;
            req_cmd1  = c1;
            req_valid = v;
            wait_ready(got);
            req_valid = 2'b00;
            model_grant(w);
            vectors++;
            if (got !== (w ? 2'b10 : 2'b01)) begin
                miscompares++;
                $display("FAIL rand_grant[%0d]: got %b want requester %0d (valid %b)", i, got, w, v);
            end
            @(negedge clk);
            vectors++;
            if (rsp_err !== (legal ? 2'b00 : (w ? 2'b10 : 2'b01))) begin
                miscompares++;
                $display("FAIL rand_err[%0d]: got %b want legal=%b owner %0d", i, rsp_err, legal, w);
            end
            if (legal) begin
                @(negedge clk);
                vectors++;
                if ({fc_go, owner, fc_cmd} !== {1'b1, w, cw}) begin
                    miscompares++;
                    $display("FAIL rand_issue[%0d]: got go=%b owner=%b cmd=%h want 1 %b %h", i, fc_go, owner, fc_cmd, w, cw);
                end
                repeat ($urandom_range(0, 3)) @(negedge clk);
                pulse_done();
                vectors++;
                if (rsp_done !== (w ? 2'b10 : 2'b01)) begin
                    miscompares++;
                    $display("FAIL rand_done[%0d]: got %b want requester %0d", i, rsp_done, w);
                end
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_cmd0  = 33'd0;
        req_cmd1  = 33'd0;
        fc_done   = 1'b0;
        m_pref    = 1'b0;
        m_streak  = 0;
        test_reset();
        test_basic();
        test_fc_wait();
        test_range();
        test_tie();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
